// File: rtl/tri_age_oldest_if.sv
// Allocation, retire and oldest-entry report bundle for tri_age_oldest.
// The master side drives requests; the slave side (the tracker) answers.
interface tri_age_oldest_if #(
    parameter int TAG_WIDTH = 5,
    parameter int IDX_W     = 3
);
    logic                 alloc_req;
    logic                 alloc_rdy;
    logic [IDX_W-1:0]     alloc_idx;
    logic [TAG_WIDTH-1:0] alloc_tag;
    logic                 dealloc_val;
    logic [IDX_W-1:0]     dealloc_idx;
    logic                 flush;
    logic                 oldest_val;
    logic [IDX_W-1:0]     oldest_idx;
    logic [TAG_WIDTH-1:0] oldest_tag;
    logic                 err;

    modport master (
        output alloc_req, dealloc_val, dealloc_idx, flush,
        input  alloc_rdy, alloc_idx, alloc_tag, oldest_val, oldest_idx, oldest_tag, err
    );

    modport slave (
        input  alloc_req, dealloc_val, dealloc_idx, flush,
        output alloc_rdy, alloc_idx, alloc_tag, oldest_val, oldest_idx, oldest_tag, err
    );
endinterface

// File: rtl/tri_age_oldest.sv
// Age tracker: hands out slots with wrap-around tags and reports the oldest valid entry.
// Define TRI_AGE_OLDEST_ERRCHK_EN to build the sticky protocol-error checker.
module tri_age_oldest #(
    parameter int DEPTH     = 8,
    parameter int TAG_WIDTH = 5,
    parameter int IDX_W     = 3
) (
    input logic             clk,
    input logic             rst,
    tri_age_oldest_if.slave bus
);
    localparam int LEAVES = 1 << IDX_W;
    localparam int NODES  = 2 * LEAVES - 1;
    localparam logic [TAG_WIDTH-1:0] HALF = {1'b1, {(TAG_WIDTH-1){1'b0}}};

    typedef struct packed {
        logic                 v;
        logic [IDX_W-1:0]     idx;
        logic [TAG_WIDTH-1:0] tag;
    } cand_t;

    // The tag MSB is the wrap bit; same wrap bit means plain order, differing means reversed.
    function automatic logic newer(input logic [TAG_WIDTH-1:0] a, input logic [TAG_WIDTH-1:0] b);
        logic lt;
        lt = a[TAG_WIDTH-2:0] < b[TAG_WIDTH-2:0];
        return (a[TAG_WIDTH-1] == b[TAG_WIDTH-1]) ? ~lt : lt;
    endfunction

    // Heap-ordered binary tournament; the left child always covers the lower indices.
    function automatic cand_t pick_oldest(input logic [DEPTH-1:0] v,
                                          input logic [DEPTH-1:0][TAG_WIDTH-1:0] t);
        cand_t                             node [NODES];
        cand_t                             l;
        cand_t                             r;
        logic [LEAVES-1:0]                 vp;
        logic [LEAVES-1:0][TAG_WIDTH-1:0]  tp;
        vp = LEAVES'(v);
        tp = (LEAVES * TAG_WIDTH)'(t);
        for (int i = 0; i < LEAVES; i++) begin
            node[LEAVES-1+i] = '{v: vp[i], idx: IDX_W'(i), tag: tp[i]};
        end
        for (int n = LEAVES - 2; n >= 0; n--) begin
            l = node[2*n+1];
            r = node[2*n+2];
            node[n] = (r.v && (!l.v || newer(l.tag, r.tag))) ? r : l;
        end
        return node[0];
    endfunction

    logic [DEPTH-1:0]                valid_q;
    logic [DEPTH-1:0]                valid_d;
    logic [DEPTH-1:0][TAG_WIDTH-1:0] tag_q;
    logic [DEPTH-1:0][TAG_WIDTH-1:0] tag_d;
    logic [TAG_WIDTH-1:0]            ctr_q;
    logic                            oldest_val_q;
    logic [IDX_W-1:0]                oldest_idx_q;
    logic [TAG_WIDTH-1:0]            oldest_tag_q;
    logic [IDX_W-1:0]                free_idx;
    logic [TAG_WIDTH-1:0]            span;
    logic                            full;
    logic                            alloc_rdy_c;
    logic                            alloc_fire;
    logic                            dealloc_ok;
    cand_t                           win;

    assign full        = &valid_q;
    assign span        = oldest_val_q ? (ctr_q - oldest_tag_q) : '0;
    assign alloc_rdy_c = ~full & (span < HALF) & ~bus.flush;
    assign alloc_fire  = bus.alloc_req & alloc_rdy_c;
    assign dealloc_ok  = bus.dealloc_val && (int'(bus.dealloc_idx) < DEPTH) && valid_q[bus.dealloc_idx];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Next-state array; only live entries can be retired, so a retire never hits the granted slot.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (dealloc_ok) valid_d[bus.dealloc_idx] = 1'b0;
        if (alloc_fire) begin
            valid_d[free_idx] = 1'b1;
            tag_d[free_idx]   = ctr_q;
        end
        if (bus.flush) valid_d = '0;
    end

    assign win = pick_oldest(valid_d, tag_d);

    // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            ctr_q        <= '0;
            oldest_val_q <= 1'b0;
            oldest_idx_q <= '0;
            oldest_tag_q <= '0;
        end else begin
            valid_q      <= valid_d;
            oldest_val_q <= win.v;
            if (alloc_fire) ctr_q <= ctr_q + TAG_WIDTH'(1);
            if (win.v) begin
                oldest_idx_q <= win.idx;
                oldest_tag_q <= win.tag;
            end
        end
    end

    // NOTE: tag storage is deliberately not reset; a tag is only read behind its valid bit.
    always_ff @(posedge clk) begin
        tag_q <= tag_d;
    end

`ifdef TRI_AGE_OLDEST_ERRCHK_EN
    logic err_q;
    logic bad;
    assign bad = (bus.alloc_req & ~alloc_rdy_c) | (bus.dealloc_val & ~dealloc_ok);

    always_ff @(posedge clk) begin
        if (rst)      err_q <= 1'b0;
        else if (bad) err_q <= 1'b1;
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.alloc_rdy  = alloc_rdy_c;
    assign bus.alloc_idx  = free_idx;
    assign bus.alloc_tag  = ctr_q;
    assign bus.oldest_val = oldest_val_q;
    assign bus.oldest_idx = oldest_idx_q;
    assign bus.oldest_tag = oldest_tag_q;
endmodule

// File: tb/tb_tri_age_oldest.sv
// Table-driven bench for tri_age_oldest: per-cycle vectors plus loops for the tag-wrap cases.
// Expected registered outputs go through a scoreboard queue and are compared after the edge.
module tb_tri_age_oldest;
    localparam int DEPTH = 8;
    localparam int TW    = 5;
    localparam int IW    = 3;

    typedef struct {
        logic          areq;
        logic          dval;
        logic [IW-1:0] didx;
        logic          flush;
        logic          e_rdy;
        logic [IW-1:0] e_aidx;
        logic [TW-1:0] e_atag;
        logic          e_oval;
        logic [IW-1:0] e_oidx;
        logic [TW-1:0] e_otag;
        logic          e_err;
    } vec_t;

    typedef struct {
        logic          oval;
        logic [IW-1:0] oidx;
        logic [TW-1:0] otag;
        logic          err;
        string         name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[19];

    always #5 clk = ~clk;

    tri_age_oldest_if #(.TAG_WIDTH(TW), .IDX_W(IW)) bus ();

    tri_age_oldest #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic err_exp(input logic e);
`ifdef TRI_AGE_OLDEST_ERRCHK_EN
        return e;
`else
        return e & 1'b0;
`endif
    endfunction

    function automatic vec_t mk(input logic areq, input logic dval, input int didx, input logic flush,
                                input logic e_rdy, input int e_aidx, input int e_atag,
                                input logic e_oval, input int e_oidx, input int e_otag,
                                input logic e_err);
        vec_t v;
        v.areq   = areq;    v.dval   = dval;       v.didx   = IW'(didx);  v.flush = flush;
        v.e_rdy  = e_rdy;   v.e_aidx = IW'(e_aidx); v.e_atag = TW'(e_atag);
        v.e_oval = e_oval;  v.e_oidx = IW'(e_oidx); v.e_otag = TW'(e_otag); v.e_err = e_err;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.alloc_req   = 1'b0;
        bus.dealloc_val = 1'b0;
        bus.dealloc_idx = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic compare_head();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got none expected entry");
        end else begin
            e = sb.pop_front();
            check({e.name, " oldest_val"}, 32'(bus.oldest_val), 32'(e.oval));
            check({e.name, " oldest_idx"}, 32'(bus.oldest_idx), 32'(e.oidx));
            check({e.name, " oldest_tag"}, 32'(bus.oldest_tag), 32'(e.otag));
            check({e.name, " err"},        32'(bus.err),        32'(e.err));
        end
    endtask

    // One cycle: drive at negedge, check the grant combinationally, check registered outputs after the edge.
    task automatic run_vec(input vec_t v, input string name);
        exp_t e;
        @(negedge clk);
        bus.alloc_req   = v.areq;
        bus.dealloc_val = v.dval;
        bus.dealloc_idx = v.didx;
        bus.flush       = v.flush;
        #1;
        check({name, " alloc_rdy"}, 32'(bus.alloc_rdy), 32'(v.e_rdy));
        if (v.e_rdy) begin
            check({name, " alloc_idx"}, 32'(bus.alloc_idx), 32'(v.e_aidx));
            check({name, " alloc_tag"}, 32'(bus.alloc_tag), 32'(v.e_atag));
        end
        e.oval = v.e_oval; e.oidx = v.e_oidx; e.otag = v.e_otag;
        e.err  = err_exp(v.e_err); e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
        compare_head();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        idle_inputs();

        //           areq dv didx fl  rdy aidx atag  oval oidx otag err
        tbl[0]  = mk(1, 0, 0, 0,  1, 0, 0,   1, 0, 0,  0);
        tbl[1]  = mk(1, 0, 0, 0,  1, 1, 1,   1, 0, 0,  0);
        tbl[2]  = mk(1, 0, 0, 0,  1, 2, 2,   1, 0, 0,  0);
        tbl[3]  = mk(0, 0, 0, 0,  1, 3, 3,   1, 0, 0,  0);
        tbl[4]  = mk(0, 1, 0, 0,  1, 3, 3,   1, 1, 1,  0);
        tbl[5]  = mk(1, 0, 0, 0,  1, 0, 3,   1, 1, 1,  0);
        tbl[6]  = mk(1, 1, 1, 0,  1, 3, 4,   1, 2, 2,  0);
        tbl[7]  = mk(1, 0, 0, 0,  1, 1, 5,   1, 2, 2,  0);
        tbl[8]  = mk(1, 0, 0, 0,  1, 4, 6,   1, 2, 2,  0);
        tbl[9]  = mk(1, 0, 0, 0,  1, 5, 7,   1, 2, 2,  0);
        tbl[10] = mk(1, 0, 0, 0,  1, 6, 8,   1, 2, 2,  0);
        tbl[11] = mk(1, 0, 0, 0,  1, 7, 9,   1, 2, 2,  0);
        tbl[12] = mk(1, 1, 3, 0,  0, 0, 0,   1, 2, 2,  1);
        tbl[13] = mk(1, 0, 0, 0,  1, 3, 10,  1, 2, 2,  1);
        tbl[14] = mk(0, 1, 2, 0,  0, 0, 0,   1, 0, 3,  1);
        tbl[15] = mk(1, 0, 0, 1,  0, 0, 0,   0, 0, 3,  1);
        tbl[16] = mk(1, 0, 0, 0,  1, 0, 11,  1, 0, 11, 1);
        tbl[17] = mk(0, 0, 0, 1,  0, 0, 0,   0, 0, 11, 1);
        tbl[18] = mk(0, 1, 5, 0,  1, 0, 12,  0, 0, 11, 1);

        do_reset();
        check("reset oldest_val", 32'(bus.oldest_val), 32'(0));
        check("reset oldest_idx", 32'(bus.oldest_idx), 32'(0));
        check("reset oldest_tag", 32'(bus.oldest_tag), 32'(0));
        check("reset err",        32'(bus.err),        32'(0));
        check("reset alloc_rdy",  32'(bus.alloc_rdy),  32'(1));
        check("reset alloc_tag",  32'(bus.alloc_tag),  32'(0));

        for (int i = 0; i < 19; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset while requesting an allocation: reset must win.
        @(negedge clk);
        rst = 1'b1;
        bus.alloc_req = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst oldest_val", 32'(bus.oldest_val), 32'(0));
        check("midrst alloc_tag",  32'(bus.alloc_tag),  32'(0));
        check("midrst alloc_idx",  32'(bus.alloc_idx),  32'(0));
        check("midrst err",        32'(bus.err),        32'(0));

        // Retiring an entry that is not live.
        run_vec(mk(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 1), "err_dealloc");
        run_vec(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "err_hold0");
        run_vec(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1), "err_hold1");
        do_reset();
        check("err_cleared", 32'(bus.err), 32'(0));

        // Tag-wrap guard: idx0 holds tag 0 while other slots churn until span reaches 16.
        run_vec(mk(1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0), "wrap_hold0");
        for (int k = 1; k < 16; k++) begin
            run_vec(mk(1, 0, 0, 0, 1, 1, k, 1, 0, 0, 0), $sformatf("wrap_alloc%0d", k));
            run_vec(mk(0, 1, 1, 0, (k + 1 < 16), 2, k + 1, 1, 0, 0, 0), $sformatf("wrap_free%0d", k));
        end
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0),  "wrap_blocked");
        run_vec(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0),  "wrap_release");
        run_vec(mk(0, 0, 0, 0, 1, 0, 16, 0, 0, 0, 0), "wrap_ready");

        // Advance the counter to 30, then age entries across the wrap: 30, 31, 0, 1.
        for (int c = 16; c < 30; c++) begin
            run_vec(mk(1, 0, 0, 0, 1, 0, c, 1, 0, c, 0),     $sformatf("adv_alloc%0d", c));
            run_vec(mk(0, 1, 0, 0, 1, 1, c + 1, 0, 0, c, 0), $sformatf("adv_free%0d", c));
        end
        run_vec(mk(1, 0, 0, 0, 1, 0, 30, 1, 0, 30, 0), "wo_a30");
        run_vec(mk(1, 0, 0, 0, 1, 1, 31, 1, 0, 30, 0), "wo_a31");
        run_vec(mk(1, 0, 0, 0, 1, 2, 0,  1, 0, 30, 0), "wo_a0");
        run_vec(mk(1, 0, 0, 0, 1, 3, 1,  1, 0, 30, 0), "wo_a1");
        run_vec(mk(0, 1, 0, 0, 1, 4, 2,  1, 1, 31, 0), "wo_d30");
        run_vec(mk(0, 1, 1, 0, 1, 0, 2,  1, 2, 0,  0), "wo_d31");
        run_vec(mk(0, 1, 2, 0, 1, 0, 2,  1, 3, 1,  0), "wo_d0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
